lru_victim_sel: RTL and testbench

- Replacement-side counterpart of the 4-way tree-PLRU state array: on a cache miss it reads the 3-bit PLRU word for the missed set and picks the victim way.
- Prefers an invalid way over the PLRU choice.
- Holds the victim stable until the fill controller accepts it.
- Then requests a PLRU write that makes the filled way MRU, through the array's shared write port with grant handshake.

---
 rtl/lru_victim_sel_if.sv | 30 +++
 rtl/lru_victim_sel.sv | 107 ++++++++++
 tb/tb_lru_victim_sel.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/lru_victim_sel_if.sv
// Miss / victim / PLRU-update signal bundle for lru_victim_sel.
// master = the victim selector, slave = its environment (cache pipe, PLRU array, fill ctrl).
interface lru_victim_sel_if #(parameter int SET_W = 13);
  logic             miss_req;
  logic             miss_rdy;
  logic [SET_W-1:0] miss_set;
  logic [3:0]       miss_val;
  logic [SET_W-1:0] lru_ra;
  logic [2:0]       lru_rd;
  logic             hit_wr;
  logic [SET_W-1:0] hit_wa;
  logic             vic_valid;
  logic [3:0]       vic_way;
  logic [SET_W-1:0] vic_set;
  logic             vic_inv;
  logic             vic_ack;
  logic             upd_req;
  logic [SET_W-1:0] upd_wa;
  logic [3:0]       upd_way_hit;
  logic             upd_gnt;

  modport master (
    input  miss_req, miss_set, miss_val, lru_rd, hit_wr, hit_wa, vic_ack, upd_gnt,
    output miss_rdy, lru_ra, vic_valid, vic_way, vic_set, vic_inv, upd_req, upd_wa, upd_way_hit
  );
  modport slave (
    output miss_req, miss_set, miss_val, lru_rd, hit_wr, hit_wa, vic_ack, upd_gnt,
    input  miss_rdy, lru_ra, vic_valid, vic_way, vic_set, vic_inv, upd_req, upd_wa, upd_way_hit
  );
endinterface

// File: rtl/lru_victim_sel.sv
// 4-way tree-PLRU victim selector: reads the set's PLRU word on a miss, prefers an
// invalid way, presents the victim until acked, then requests an MRU update write.
module lru_victim_sel #(
  parameter int SET_W = 13
) (
  input  logic            clk,
  input  logic            reset_n,
  lru_victim_sel_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, DECIDE, UPD} state_t;

  state_t           state, state_nxt;
  logic [SET_W-1:0] set_q;
  logic [3:0]       val_q;
  logic             snoop_hit;

  logic             miss_rdy_q, vic_valid_q, vic_inv_q, upd_req_q;
  logic [SET_W-1:0] lru_ra_q, vic_set_q, upd_wa_q;
  logic [3:0]       vic_way_q, upd_way_q;

  // Invalid ways win (lowest index first); otherwise follow the PLRU tree pointers.
  function automatic logic [3:0] pick_victim(input logic [3:0] val, input logic [2:0] b);
    logic [3:0] w;
    w = 4'b0000;
    if (val != 4'hF) begin
      for (int i = 3; i >= 0; i--)
        if (!val[i]) w = 4'b0001 << i;
    end else if (!b[2]) begin
      w = b[1] ? 4'b0100 : 4'b1000;
    end else begin
      w = b[0] ? 4'b0001 : 4'b0010;
    end
    return w;
  endfunction

  // A same-cycle hit write to our set means the word we are reading is stale.
  assign snoop_hit = bus.hit_wr && (bus.hit_wa == set_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.miss_req)  state_nxt = READ;
      READ:    if (!snoop_hit)    state_nxt = DECIDE;
      DECIDE:  if (bus.vic_ack)   state_nxt = UPD;
      UPD:     if (bus.upd_gnt)   state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      set_q       <= '0;
      val_q       <= '0;
      miss_rdy_q  <= 1'b1;
      lru_ra_q    <= '0;
      vic_valid_q <= 1'b0;
      vic_way_q   <= '0;
      vic_set_q   <= '0;
      vic_inv_q   <= 1'b0;
      upd_req_q   <= 1'b0;
      upd_wa_q    <= '0;
      upd_way_q   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.miss_req) begin
          set_q      <= bus.miss_set;
          val_q      <= bus.miss_val;
          lru_ra_q   <= bus.miss_set;
          miss_rdy_q <= 1'b0;
        end
        READ: if (!snoop_hit) begin
          vic_way_q   <= pick_victim(val_q, bus.lru_rd);
          vic_inv_q   <= (val_q != 4'hF);
          vic_set_q   <= set_q;
          vic_valid_q <= 1'b1;
        end
        DECIDE: if (bus.vic_ack) begin
          vic_valid_q <= 1'b0;
          upd_req_q   <= 1'b1;
          upd_wa_q    <= set_q;
          upd_way_q   <= vic_way_q;
        end
        UPD: if (bus.upd_gnt) begin
          upd_req_q  <= 1'b0;
          miss_rdy_q <= 1'b1;
          lru_ra_q   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.miss_rdy    = miss_rdy_q;
  assign bus.lru_ra      = lru_ra_q;
  assign bus.vic_valid   = vic_valid_q;
  assign bus.vic_way     = vic_way_q;
  assign bus.vic_set     = vic_set_q;
  assign bus.vic_inv     = vic_inv_q;
  assign bus.upd_req     = upd_req_q;
  assign bus.upd_wa      = upd_wa_q;
  assign bus.upd_way_hit = upd_way_q;
endmodule

// File: tb/tb_lru_victim_sel.sv
// Directed bench for lru_victim_sel: expected victims queued at miss issue, popped in DECIDE.
module tb_lru_victim_sel;
  logic clk, reset_n;
  int   passed = 0, total = 0;

  typedef struct {
    logic [3:0]  way;
    logic [12:0] set;
    logic        inv;
  } exp_t;
  exp_t q[$];

  lru_victim_sel_if #(.SET_W(13)) bus();
  lru_victim_sel #(.SET_W(13)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] model_way(input logic [3:0] v, input logic [2:0] w);
    if (!v[0]) return 4'b0001;
    if (!v[1]) return 4'b0010;
    if (!v[2]) return 4'b0100;
    if (!v[3]) return 4'b1000;
    case (w[2])
      1'b0:    return w[1] ? 4'b0100 : 4'b1000;
      default: return w[0] ? 4'b0001 : 4'b0010;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_miss(input logic [12:0] s, input logic [3:0] v, input logic [2:0] w,
                          input int ack_dly, input int gnt_dly,
                          input bit snp_rd, input logic [2:0] w2, input bit snp_dec);
    exp_t e, g;
    e.way = model_way(v, snp_rd ? w2 : w);
    e.set = s;
    e.inv = (v != 4'hF);
    q.push_back(e);
    @(negedge clk);
    chk("idle_rdy", bus.miss_rdy, 1);
    bus.miss_req = 1; bus.miss_set = s; bus.miss_val = v; bus.lru_rd = w;
    @(posedge clk); #1;
    bus.miss_req = 0; bus.miss_set = 13'($urandom); bus.miss_val = 4'($urandom);
    chk("read_ra", bus.lru_ra, s);
    chk("read_rdy", bus.miss_rdy, 0);
    chk("read_vld", bus.vic_valid, 0);
    if (snp_rd) begin
      bus.hit_wr = 1; bus.hit_wa = s;
      @(posedge clk); #1;
      bus.hit_wr = 0; bus.lru_rd = w2;
      chk("snp_read_vld", bus.vic_valid, 0);
      chk("snp_read_ra", bus.lru_ra, s);
    end
    @(posedge clk); #1;
    g = q.pop_front();
    chk("dec_vld", bus.vic_valid, 1);
    chk("dec_way", bus.vic_way, g.way);
    chk("dec_set", bus.vic_set, g.set);
    chk("dec_inv", bus.vic_inv, g.inv);
    if (snp_dec) begin
      bus.hit_wr = 1; bus.hit_wa = s; bus.lru_rd = ~w;
      @(posedge clk); #1;
      bus.hit_wr = 0;
      chk("dec_snp_way", bus.vic_way, g.way);
      chk("dec_snp_vld", bus.vic_valid, 1);
    end
    for (int i = 0; i < ack_dly; i++) begin
      bus.miss_req = 1; bus.miss_set = s ^ 13'h1; bus.upd_gnt = 1;
      @(posedge clk); #1;
      bus.miss_req = 0; bus.upd_gnt = 0;
      chk("ackw_vld", bus.vic_valid, 1);
      chk("ackw_way", bus.vic_way, g.way);
      chk("ackw_set", bus.vic_set, g.set);
      chk("ackw_rdy", bus.miss_rdy, 0);
      chk("ackw_upd", bus.upd_req, 0);
    end
    bus.vic_ack = 1;
    @(posedge clk); #1;
    bus.vic_ack = 0;
    chk("upd_req", bus.upd_req, 1);
    chk("upd_wa", bus.upd_wa, s);
    chk("upd_way", bus.upd_way_hit, g.way);
    chk("upd_vld_off", bus.vic_valid, 0);
    for (int i = 0; i < gnt_dly; i++) begin
      bus.miss_req = 1; bus.miss_set = s ^ 13'h2; bus.vic_ack = 1;
      @(posedge clk); #1;
      bus.miss_req = 0; bus.vic_ack = 0;
      chk("gntw_req", bus.upd_req, 1);
      chk("gntw_wa", bus.upd_wa, s);
      chk("gntw_way", bus.upd_way_hit, g.way);
      chk("gntw_rdy", bus.miss_rdy, 0);
    end
    bus.upd_gnt = 1;
    @(posedge clk); #1;
    bus.upd_gnt = 0;
    chk("done_req", bus.upd_req, 0);
    chk("done_rdy", bus.miss_rdy, 1);
    chk("done_ra", bus.lru_ra, 0);
  endtask

  task automatic abort_at(input logic [12:0] s, input bit in_upd);
    @(negedge clk);
    bus.miss_req = 1; bus.miss_set = s; bus.miss_val = 4'hF; bus.lru_rd = 3'b000;
    @(posedge clk); #1;
    bus.miss_req = 0;
    @(posedge clk); #1;
    chk("abort_pre_vld", bus.vic_valid, 1);
    if (in_upd) begin
      bus.vic_ack = 1;
      @(posedge clk); #1;
      bus.vic_ack = 0;
      chk("abort_pre_upd", bus.upd_req, 1);
    end
    #2 reset_n = 0;
    #1;
    chk("abort_vld", bus.vic_valid, 0);
    chk("abort_upd", bus.upd_req, 0);
    chk("abort_rdy", bus.miss_rdy, 1);
    chk("abort_ra", bus.lru_ra, 0);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0;
    bus.miss_req = 0; bus.miss_set = '0; bus.miss_val = '0; bus.lru_rd = '0;
    bus.hit_wr = 0; bus.hit_wa = '0; bus.vic_ack = 0; bus.upd_gnt = 0;
    #12;
    chk("rst_rdy", bus.miss_rdy, 1);
    chk("rst_vld", bus.vic_valid, 0);
    chk("rst_upd", bus.upd_req, 0);
    chk("rst_way", bus.vic_way, 0);
    chk("rst_uway", bus.upd_way_hit, 0);
    chk("rst_set", bus.vic_set, 0);
    chk("rst_wa", bus.upd_wa, 0);
    chk("rst_ra", bus.lru_ra, 0);
    chk("rst_inv", bus.vic_inv, 0);
    @(negedge clk);
    reset_n = 1;

    // basic miss, array word zero
    run_miss(13'h0005, 4'hF, 3'b000, 0, 0, 0, 3'b000, 0);
    // PLRU decode sweep
    run_miss(13'h0010, 4'hF, 3'b010, 0, 0, 0, 3'b000, 0);
    run_miss(13'h0011, 4'hF, 3'b100, 0, 0, 0, 3'b000, 0);
    run_miss(13'h0012, 4'hF, 3'b101, 0, 0, 0, 3'b000, 0);
    run_miss(13'h1FFF, 4'hF, 3'b111, 0, 0, 0, 3'b000, 0);
    // invalid-way preference
    run_miss(13'h0020, 4'b1010, 3'b111, 0, 0, 0, 3'b000, 0);
    run_miss(13'h0021, 4'b1011, 3'b111, 0, 0, 0, 3'b000, 0);
    run_miss(13'h0022, 4'b0111, 3'b101, 0, 0, 0, 3'b000, 0);
    // snoop during READ, then during DECIDE
    run_miss(13'h0123, 4'hF, 3'b000, 0, 0, 1, 3'b010, 0);
    run_miss(13'h0077, 4'hF, 3'b101, 0, 0, 0, 3'b000, 1);
    // backpressure on ack and grant
    run_miss(13'h0ABC, 4'hF, 3'b100, 5, 3, 0, 3'b000, 0);
    // async reset abort in DECIDE and UPD, each followed by a clean miss
    abort_at(13'h0042, 0);
    run_miss(13'h0043, 4'hF, 3'b010, 0, 0, 0, 3'b000, 0);
    abort_at(13'h0044, 1);
    run_miss(13'h0045, 4'b1110, 3'b000, 1, 1, 0, 3'b000, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
